// File: rtl/twiddle_cmul.sv
// -----------------------------------------------------------------------------
// twiddle_cmul
//
// Multiplies one sign-magnitude complex sample by the FFT twiddle factor
//   W^k = cos(2*pi*k/N_PTS) - j*sin(2*pi*k/N_PTS)
// giving out_re = re*c + im*s and out_im = im*c - re*s. Data use DATA_W-bit
// sign-magnitude with 11 fraction bits. Twiddles are 12-bit sign-magnitude.
//
// Pipeline (3 stages, one result per cycle, single global advance enable):
//   stage 1 : register sample, look up twiddle (c, s)
//   stage 2 : register the four sign-magnitude products
//   stage 3 : add pairs, convert to sign-magnitude, round/saturate, register
//
// Build option: define TWIDDLE_CMUL_ROUND_EN to round half up on magnitude
// (add 2^10 before the >>11). The default build truncates toward zero.
//
// Parameters
//   DATA_W    sample width (1 sign + DATA_W-1 magnitude bits)
//   N_PTS     FFT size: 8, 16 or 32
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_re/im   input sample, sign-magnitude
//   in_k       twiddle index, log2(N_PTS)-1 bits
//   in_valid   input handshake valid      in_ready   input handshake ready
//   out_re/im  result, sign-magnitude
//   out_valid  output handshake valid     out_ready  output handshake ready
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module twiddle_cmul #(
  parameter int DATA_W = 22,
  parameter int N_PTS  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_W-1:0]          in_re,
  input  logic [DATA_W-1:0]          in_im,
  input  logic [$clog2(N_PTS)-2:0]   in_k,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [DATA_W-1:0]          out_re,
  output logic [DATA_W-1:0]          out_im,
  output logic                       out_valid,
  input  logic                       out_ready
);

  localparam int MAG_W   = DATA_W - 1;       // data magnitude bits
  localparam int FRAC    = 11;               // fraction bits of data and twiddle
  localparam int PW      = MAG_W + 12;       // product magnitude (twiddle up to 2^11)
  localparam int SW      = PW + 2;           // two's complement sum (sign + carry)
  localparam int J_SHIFT = $clog2(32 / N_PTS);

  localparam logic [MAG_W-1:0] MAX_MAG = '1;
`ifdef TWIDDLE_CMUL_ROUND_EN
  localparam logic [SW-1:0] ROUND_BIAS = SW'(1) << (FRAC - 1);
`endif

  typedef struct packed {
    logic          sgn;
    logic [PW-1:0] mag;
  } prod_t;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  // Quarter-wave magnitude table, 11-bit: index 0 is 1.0 (coded 0x7FF), 8 is 0.
  function automatic logic [10:0] tab_mag(input logic [3:0] m);
    logic [10:0] v;
    case (m)
      4'd0:    v = 11'h7FF;
      4'd1:    v = 11'h7D8;
      4'd2:    v = 11'h764;
      4'd3:    v = 11'h6A7;
      4'd4:    v = 11'h5A8;
      4'd5:    v = 11'h472;
      4'd6:    v = 11'h310;
      4'd7:    v = 11'h18F;
      default: v = 11'h000;
    endcase
    return v;
  endfunction

  // Unsigned magnitude product; 0x7FF stands for exactly 1.0, so that entry is
  // a plain shift instead of a multiply by 2047.
  function automatic prod_t mul_sm(input logic [DATA_W-1:0] d, input logic [11:0] t);
    prod_t p;
    p.sgn = d[DATA_W-1] ^ t[11];
    if (t[10:0] == 11'h7FF) p.mag = PW'({d[MAG_W-1:0], 11'b0});
    else                    p.mag = PW'(d[MAG_W-1:0]) * PW'(t[10:0]);
    return p;
  endfunction

  function automatic logic signed [SW-1:0] to_tc(input prod_t p);
    logic signed [SW-1:0] v;
    v = signed'({2'b00, p.mag});
    return p.sgn ? -v : v;
  endfunction

  // Full-precision sum -> sign-magnitude result with >>11, saturation and +0.
  function automatic logic [DATA_W-1:0] to_sm(input logic signed [SW-1:0] sum);
    logic [SW-1:0]     mag;
    logic [SW-1:0]     shifted;
    logic [DATA_W-1:0] res;
    mag = sum[SW-1] ? $unsigned(-sum) : $unsigned(sum);
`ifdef TWIDDLE_CMUL_ROUND_EN
    mag = mag + ROUND_BIAS;
`endif
    shifted = mag >> FRAC;
    if (shifted > SW'(MAX_MAG)) res = {sum[SW-1], MAX_MAG};
    else if (shifted == '0)     res = '0;  // never emit -0
    else                        res = {sum[SW-1], shifted[MAG_W-1:0]};
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // Global advance enable: the whole pipe moves or the whole pipe holds.
  // ---------------------------------------------------------------------------
  logic w_en;
  logic r_out_valid;

  assign w_en     = !r_out_valid || out_ready;
  assign in_ready = w_en;

  // ---------------------------------------------------------------------------
  // Stage 1 lookup: j = k * (32/N_PTS) folds every N_PTS onto the 32-point table
  // ---------------------------------------------------------------------------
  logic [3:0]  w_j;
  logic [11:0] w_c;
  logic [11:0] w_s;

  assign w_j = 4'(in_k) << J_SHIFT;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_c = '0;
    w_s = '0;
    if (w_j <= 4'd8) begin
      w_c = {1'b0, tab_mag(w_j)};
      w_s = {1'b0, tab_mag(4'd8 - w_j)};
    end else begin
      // Second quadrant: cosine goes negative, sine mirrors back down.
      w_c = {1'b1, tab_mag(4'(5'd16 - {1'b0, w_j}))};
      w_s = {1'b0, tab_mag(w_j - 4'd8)};
    end
  end

  // ---------------------------------------------------------------------------
  // Stage registers
  // ---------------------------------------------------------------------------
  logic              r1_valid;
  logic [DATA_W-1:0] r1_re;
  logic [DATA_W-1:0] r1_im;
  logic [11:0]       r1_c;
  logic [11:0]       r1_s;

  logic              r2_valid;
  prod_t             r2_rc;   // re*c
  prod_t             r2_is;   // im*s
  prod_t             r2_ic;   // im*c
  prod_t             r2_rs;   // re*s

  logic [DATA_W-1:0] r_out_re;
  logic [DATA_W-1:0] r_out_im;

  // Stage 3 combinational: add/subtract pairs, then convert.
  logic signed [SW-1:0] w_sum_re;
  logic signed [SW-1:0] w_sum_im;
  logic [DATA_W-1:0]    w_res_re;
  logic [DATA_W-1:0]    w_res_im;

  assign w_sum_re = to_tc(r2_rc) + to_tc(r2_is);
  assign w_sum_im = to_tc(r2_ic) - to_tc(r2_rs);
  assign w_res_re = to_sm(w_sum_re);
  assign w_res_im = to_sm(w_sum_im);

  // Control and output registers: these carry reset.
  // NOTE: sequential state uses non-blocking (<=) so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r1_valid    <= 1'b0;
      r2_valid    <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_re    <= '0;
      r_out_im    <= '0;
    end else if (w_en) begin
      r1_valid    <= in_valid;
      r2_valid    <= r1_valid;
      r_out_valid <= r2_valid;
      r_out_re    <= w_res_re;
      r_out_im    <= w_res_im;
    end
  end

  // NOTE: internal datapath registers are not reset; the valid bits already mark their contents as don't-care.
  always_ff @(posedge clk) begin
    if (w_en) begin
      r1_re <= in_re;
      r1_im <= in_im;
      r1_c  <= w_c;
      r1_s  <= w_s;
      r2_rc <= mul_sm(r1_re, r1_c);
      r2_is <= mul_sm(r1_im, r1_s);
      r2_ic <= mul_sm(r1_im, r1_c);
      r2_rs <= mul_sm(r1_re, r1_s);
    end
  end

  assign out_re    = r_out_re;
  assign out_im    = r_out_im;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_twiddle_cmul.sv
// -----------------------------------------------------------------------------
// tb_twiddle_cmul
//
// Scoreboard bench for twiddle_cmul (DATA_W=22, N_PTS=32). The driver pushes
// the expected result of every accepted sample into a queue; an independent
// monitor pops and compares on each output transfer, and checks that outputs
// hold while stalled. Expected values come from hand-derived constants for the
// directed cases and from an integer reference model for random traffic.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_twiddle_cmul;

  localparam int     DATA_W = 22;
  localparam int     N_PTS  = 32;
  localparam longint MAXM   = (64'sd1 <<< 21) - 1;
  localparam int     TAB [9] = '{2047, 2008, 1892, 1703, 1448, 1138, 784, 399, 0};

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DATA_W-1:0] in_re = '0;
  logic [DATA_W-1:0] in_im = '0;
  logic [3:0]        in_k = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] out_re;
  logic [DATA_W-1:0] out_im;
  logic              out_valid;
  logic              out_ready = 1'b1;

  always #5 clk = ~clk;

  twiddle_cmul #(.DATA_W(DATA_W), .N_PTS(N_PTS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_re     (in_re),
    .in_im     (in_im),
    .in_k      (in_k),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_re    (out_re),
    .out_im    (out_im),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  typedef struct {
    logic [DATA_W-1:0] re;
    logic [DATA_W-1:0] im;
  } exp_t;

  typedef enum {RDY_ONE, RDY_ZERO, RDY_RAND} rdy_mode_e;

  exp_t      exp_q[$];
  int        n_tests = 0;
  int        n_fail  = 0;
  rdy_mode_e rdy_mode = RDY_ONE;

  // ---------------------------------------------------------------------------
  // Reference model: plain integer arithmetic on signed values
  // ---------------------------------------------------------------------------
  function automatic logic [DATA_W-1:0] sm(input longint v);
    logic [20:0] m;
    m = 21'(v < 0 ? -v : v);
    return {(v < 0), m};
  endfunction

  function automatic longint sm2int(input logic [DATA_W-1:0] x);
    longint m;
    m = longint'(x[20:0]);
    return x[21] ? -m : m;
  endfunction

  function automatic longint tw(input int m);
    return (TAB[m] == 2047) ? 2048 : longint'(TAB[m]);
  endfunction

  function automatic logic [DATA_W-1:0] finish(input longint x);
    longint m;
    m = (x < 0) ? -x : x;
`ifdef TWIDDLE_CMUL_ROUND_EN
    m = m + 1024;
`endif
    m = m / 2048;
    if (m > MAXM) m = MAXM;
    if (m == 0) return '0;
    return {(x < 0), 21'(m)};
  endfunction

  function automatic exp_t model(input logic [DATA_W-1:0] re, input logic [DATA_W-1:0] im,
                                 input int k);
    longint a, b, c, s;
    int     j;
    exp_t   e;
    a = sm2int(re);
    b = sm2int(im);
    j = k * (32 / N_PTS);
    if (j <= 8) begin c = tw(j);       s = tw(8 - j); end
    else        begin c = -tw(16 - j); s = tw(j - 8); end
    e.re = finish(a * c + b * s);
    e.im = finish(b * c - a * s);
    return e;
  endfunction

  function automatic exp_t mk(input longint re, input longint im);
    exp_t e;
    e.re = sm(re);
    e.im = sm(im);
    return e;
  endfunction

  function automatic logic [DATA_W-1:0] rand_sm();
    int unsigned mag;
    if ($urandom_range(0, 3) == 0) mag = $urandom_range(2097136, 2097151);
    else                           mag = $urandom_range(0, 2097151);
    return {1'($urandom_range(0, 1)), 21'(mag)};
  endfunction

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: decides at mid-cycle whether the coming edge retires an output.
  initial begin : monitor
    logic              stalled;
    logic [DATA_W-1:0] s_re, s_im;
    exp_t              e;
    stalled = 1'b0;
    s_re = '0;
    s_im = '0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          check("stall_valid", out_valid, 1);
          check("stall_re", out_re, s_re);
          check("stall_im", out_im, s_im);
        end
        if (out_valid === 1'b1 && out_ready) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL spurious_out: got re=%0h im=%0h, expected no output", out_re, out_im);
          end else begin
            e = exp_q.pop_front();
            check("out_re", out_re, e.re);
            check("out_im", out_im, e.im);
          end
        end
        stalled = (out_valid === 1'b1) && !out_ready;
        s_re = out_re;
        s_im = out_im;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------------
  task automatic drive_cycle(input logic v, input logic [DATA_W-1:0] re,
                             input logic [DATA_W-1:0] im, input logic [3:0] k,
                             output logic tk);
    @(negedge clk);
    in_valid = v;
    in_re    = re;
    in_im    = im;
    in_k     = k;
    case (rdy_mode)
      RDY_ONE:  out_ready = 1'b1;
      RDY_ZERO: out_ready = 1'b0;
      default:  out_ready = 1'($urandom_range(0, 1));
    endcase
    #1;
    tk = v && (in_ready === 1'b1);
  endtask

  task automatic send_exp(input logic [DATA_W-1:0] re, input logic [DATA_W-1:0] im,
                          input logic [3:0] k, input exp_t e, output int cycles);
    logic tk;
    cycles = 0;
    do begin
      drive_cycle(1'b1, re, im, k, tk);
      cycles++;
    end while (!tk && cycles < 200);
    if (tk) exp_q.push_back(e);
    else begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: in_ready low for %0d cycles, expected acceptance", cycles);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_rand(output int cycles);
    logic [DATA_W-1:0] re, im;
    logic [3:0]        k;
    re = rand_sm();
    im = rand_sm();
    k  = 4'($urandom_range(0, 15));
    send_exp(re, im, k, model(re, im, int'(k)), cycles);
  endtask

  task automatic idle(input int n);
    logic tk;
    repeat (n) drive_cycle(1'b0, '0, '0, 4'd0, tk);
  endtask

  task automatic drain();
    int   c;
    logic tk;
    rdy_mode = RDY_ONE;
    c = 0;
    while (exp_q.size() != 0 && c < 200) begin
      drive_cycle(1'b0, '0, '0, 4'd0, tk);
      c++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  // Sample into an empty pipe with out_ready=1: out_valid must rise 3 cycles later.
  task automatic latency_case(input string name, input longint re, input longint im,
                              input logic [3:0] k, input exp_t e);
    int   cyc;
    logic tk;
    rdy_mode = RDY_ONE;
    send_exp(sm(re), sm(im), k, e, cyc);
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b0, '0, '0, 4'd0, tk);
      check($sformatf("%s_lat%0d", name, i), out_valid, (i == 2) ? 1 : 0);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin : main
    int   cyc, total;
    exp_t e;

    // Reset state
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_re", out_re, 0);
    check("rst_out_im", out_im, 0);
    check("rst_in_ready", in_ready, 1);
    rst = 1'b0;
    idle(2);

    // Directed cases
    latency_case("k0", 2048, -1000, 4'd0, mk(2048, -1000));
    latency_case("k8", 2048, 0, 4'd8, mk(0, -2048));
    latency_case("k4", 2048, 0, 4'd4, mk(1448, -1448));
    latency_case("k4_sat", -MAXM, MAXM, 4'd4, mk(0, MAXM));
`ifdef TWIDDLE_CMUL_ROUND_EN
    latency_case("k1_small", 1, 0, 4'd1, mk(1, 0));
`else
    latency_case("k1_small", 1, 0, 4'd1, mk(0, 0));
`endif
    latency_case("k12", 2048, 0, 4'd12, mk(-1448, -1448));
    latency_case("k0_full", MAXM, -MAXM, 4'd0, mk(MAXM, -MAXM));
    // Negative-zero input must come back as +0
    e = mk(0, 0);
    send_exp({1'b1, 21'd0}, {1'b1, 21'd0}, 4'd3, e, cyc);
    drain();

    // 20-sample burst with random out_ready back-pressure
    rdy_mode = RDY_RAND;
    for (int i = 0; i < 20; i++) send_rand(cyc);
    drain();

    // Back-to-back throughput with out_ready held high
    rdy_mode = RDY_ONE;
    total = 0;
    for (int i = 0; i < 16; i++) begin
      send_rand(cyc);
      total += cyc;
    end
    check("throughput_cycles", total, 16);
    drain();

    // Reset with three samples in flight: none may ever be delivered
    rdy_mode = RDY_ZERO;
    for (int i = 0; i < 3; i++) send_rand(cyc);
    @(negedge clk);
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    rdy_mode = RDY_ONE;
    idle(5);
    latency_case("post_rst", -700, 300, 4'd6, model(sm(-700), sm(300), 6));
    drain();

    // A little more random traffic after the reset
    rdy_mode = RDY_RAND;
    for (int i = 0; i < 10; i++) send_rand(cyc);
    drain();
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
